// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, flit field positions and the XY routing function.
package noc_pkg;

  localparam int FLIT_W    = 16;
  localparam int NUM_PORTS = 5;

  localparam int P_N = 0;
  localparam int P_S = 1;
  localparam int P_E = 2;
  localparam int P_W = 3;
  localparam int P_L = 4;

  localparam int HEAD_BIT = 15;
  localparam int TAIL_BIT = 14;
  localparam int DX_MSB   = 13;
  localparam int DX_LSB   = 10;
  localparam int DY_MSB   = 9;
  localparam int DY_LSB   = 6;

  typedef logic [2:0] port_idx_t;

  typedef enum logic {
    OUT_IDLE,
    OUT_LOCKED
  } out_state_e;

  // X is resolved completely before Y, which keeps XY routing deadlock-free on a mesh.
  function automatic port_idx_t xy_route(
    input logic [3:0] dst_x,
    input logic [3:0] dst_y,
    input logic [3:0] my_x,
    input logic [3:0] my_y
  );
    port_idx_t r;
    if (dst_x > my_x)      r = port_idx_t'(P_E);
    else if (dst_x < my_x) r = port_idx_t'(P_W);
    else if (dst_y > my_y) r = port_idx_t'(P_N);
    else if (dst_y < my_y) r = port_idx_t'(P_S);
    else                   r = port_idx_t'(P_L);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Five-way round-robin arbiter; the pointer moves one past the winner whenever a grant is taken.
module rr_arbiter
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 advance_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output port_idx_t            grant_idx_o
);

  port_idx_t ptr_q;
  port_idx_t ptr_d;
  port_idx_t cand;

  // Scan from the farthest offset down so the requester closest to the pointer is the last one written.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    cand        = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = port_idx_t'((int'(ptr_q) + k) % NUM_PORTS);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (|grant_o)) begin
      ptr_d = (grant_idx_o == port_idx_t'(NUM_PORTS - 1)) ? '0 : grant_idx_o + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/switch_allocator.sv
// Router switch allocator: XY route per input head flit, per-output wormhole lock with round-robin grant,
// and combinational pop / crossbar-select generation for the locked owner.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int MY_X = 0,
  parameter int MY_Y = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              empty_i,
  input  logic [NUM_PORTS-1:0][FLIT_W-1:0]  head_flit_i,
  input  logic [NUM_PORTS-1:0]              ready_i,
  output logic [NUM_PORTS-1:0]              pop_req_o,
  output logic [NUM_PORTS-1:0][2:0]         sel_o,
  output logic [NUM_PORTS-1:0]              valid_o,
  output logic [NUM_PORTS-1:0]              busy_o
);

  localparam logic [3:0] MY_X_L = 4'(MY_X);
  localparam logic [3:0] MY_Y_L = 4'(MY_Y);

  port_idx_t              route [NUM_PORTS];
  port_idx_t              owner [NUM_PORTS];
  logic [NUM_PORTS-1:0]   in_req;
  logic [NUM_PORTS-1:0]   in_locked;
  logic [NUM_PORTS-1:0]   fire;

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_in
    assign route[gi]  = xy_route(head_flit_i[gi][DX_MSB:DX_LSB], head_flit_i[gi][DY_MSB:DY_LSB],
                                 MY_X_L, MY_Y_L);
    // A body flit at the head of an unlocked input is never requested, so it simply stalls there.
    assign in_req[gi] = !empty_i[gi] && head_flit_i[gi][HEAD_BIT] && !in_locked[gi];
  end

  always_comb begin
    in_locked = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (busy_o[o]) in_locked[owner[o]] = 1'b1;
    end
  end

  always_comb begin
    pop_req_o = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (fire[o]) pop_req_o[owner[o]] = 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
    out_state_e           state_q, state_d;
    port_idx_t            owner_q, owner_d;
    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] arb_grant;
    port_idx_t            arb_idx;
    logic                 fire_l;

    always_comb begin
      arb_req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        arb_req[i] = (state_q == OUT_IDLE) && in_req[i] && (route[i] == port_idx_t'(gi));
      end
    end

    rr_arbiter u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (arb_req),
      .advance_i   (state_q == OUT_IDLE),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx)
    );

    always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      fire_l  = 1'b0;
      case (state_q)
        OUT_IDLE: begin
          if (|arb_grant) begin
            state_d = OUT_LOCKED;
            owner_d = arb_idx;
          end
        end
        OUT_LOCKED: begin
          fire_l = ready_i[gi] && !empty_i[owner_q];
          if (fire_l && head_flit_i[owner_q][TAIL_BIT]) state_d = OUT_IDLE;
        end
        default: state_d = OUT_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= OUT_IDLE;
        owner_q <= '0;
      end else begin
        state_q <= state_d;
        owner_q <= owner_d;
      end
    end

    assign fire[gi]    = fire_l;
    assign owner[gi]   = owner_q;
    assign busy_o[gi]  = (state_q == OUT_LOCKED);
    assign valid_o[gi] = fire_l;
    assign sel_o[gi]   = fire_l ? owner_q : 3'd0;
  end

  // Payload bits never influence allocation.
  logic unused_payload;
  always_comb begin
    unused_payload = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) unused_payload = unused_payload ^ (^head_flit_i[i][5:0]);
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: FIFO queues per input, a packet-level reference model, directed and random traffic.
module tb_switch_allocator;

  localparam int MY_X = 2;
  localparam int MY_Y = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       empty_i, ready_i;
  logic [4:0][15:0] head_flit_i;
  logic [4:0]       pop_req_o, valid_o, busy_o;
  logic [4:0][2:0]  sel_o;

  always #5 clk = ~clk;

  switch_allocator #(.MY_X(MY_X), .MY_Y(MY_Y)) dut (
    .clk         (clk),
    .rst         (rst),
    .empty_i     (empty_i),
    .head_flit_i (head_flit_i),
    .ready_i     (ready_i),
    .pop_req_o   (pop_req_o),
    .sel_o       (sel_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Input buffers as queues; gap[i] hides a non-empty queue to model a momentarily empty buffer.
  logic [15:0] fifo_q [5][$];
  bit          gap [5];

  // Reference: each output is either free or owned by a packet from one input, plus a priority pointer.
  bit m_locked [5];
  int m_owner  [5];
  int m_ptr    [5];
  bit n_locked [5];
  int n_owner  [5];
  int n_ptr    [5];
  bit m_fire   [5];
  logic [4:0]      exp_pop, exp_valid, exp_busy;
  logic [4:0][2:0] exp_sel;

  function automatic int route_of(input logic [15:0] f);
    int dx = int'(f[13:10]);
    int dy = int'(f[9:6]);
    if (dx > MY_X) return 2;
    if (dx < MY_X) return 3;
    if (dy > MY_Y) return 0;
    if (dy < MY_Y) return 1;
    return 4;
  endfunction

  task automatic push_pkt(input int src, input int dx, input int dy, input int len);
    for (int k = 0; k < len; k++) begin
      fifo_q[src].push_back({(k == 0), (k == len - 1), 4'(dx), 4'(dy), 6'($urandom_range(0, 63))});
    end
  endtask

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_locked[o] = 0;
      m_owner[o]  = 0;
      m_ptr[o]    = 0;
    end
  endtask

  task automatic model_eval();
    bit in_busy [5];
    for (int i = 0; i < 5; i++) in_busy[i] = 0;
    for (int o = 0; o < 5; o++) if (m_locked[o]) in_busy[m_owner[o]] = 1;
    exp_pop = '0; exp_valid = '0; exp_busy = '0; exp_sel = '0;
    for (int o = 0; o < 5; o++) begin
      n_locked[o] = m_locked[o];
      n_owner[o]  = m_owner[o];
      n_ptr[o]    = m_ptr[o];
      m_fire[o]   = 0;
      if (m_locked[o]) begin
        exp_busy[o] = 1'b1;
        if (ready_i[o] && !empty_i[m_owner[o]]) begin
          m_fire[o]             = 1;
          exp_pop[m_owner[o]]   = 1'b1;
          exp_valid[o]          = 1'b1;
          exp_sel[o]            = 3'(m_owner[o]);
          if (head_flit_i[m_owner[o]][14]) n_locked[o] = 0;
        end
      end else begin
        for (int k = 0; k < 5; k++) begin
          int i = (m_ptr[o] + k) % 5;
          if (!empty_i[i] && head_flit_i[i][15] && !in_busy[i] && route_of(head_flit_i[i]) == o) begin
            n_locked[o] = 1;
            n_owner[o]  = i;
            n_ptr[o]    = (i + 1) % 5;
            break;
          end
        end
      end
    end
  endtask

  // Called just after a falling edge: drive buffer heads, then compare against the model.
  task automatic drive_and_check();
    for (int i = 0; i < 5; i++) begin
      empty_i[i]     = (fifo_q[i].size() == 0) || gap[i];
      head_flit_i[i] = (fifo_q[i].size() != 0) ? fifo_q[i][0] : 16'h0;
    end
    #1;
    model_eval();
    check_val("pop_req", 32'(pop_req_o), 32'(exp_pop));
    check_val("valid",   32'(valid_o),   32'(exp_valid));
    check_val("sel",     32'(sel_o),     32'(exp_sel));
    check_val("busy",    32'(busy_o),    32'(exp_busy));
  endtask

  task automatic commit();
    @(posedge clk);
    for (int o = 0; o < 5; o++) begin
      if (m_fire[o] && head_flit_i[m_owner[o]][14])
        $display("packet done: out=%0d src=%0d t=%0t", o, m_owner[o], $time);
      m_locked[o] = n_locked[o];
      m_owner[o]  = n_owner[o];
      m_ptr[o]    = n_ptr[o];
    end
    for (int i = 0; i < 5; i++) if (exp_pop[i]) void'(fifo_q[i].pop_front());
    @(negedge clk);
  endtask

  task automatic step();
    drive_and_check();
    commit();
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < 5; i++) p += fifo_q[i].size() + int'(m_locked[i]);
    return p;
  endfunction

  initial begin
    automatic int b_seq [9] = '{0, 1, 1, 1, 0, 2, 2, 2, 0};
    rst = 1'b1;
    ready_i = 5'h1F;
    empty_i = 5'h1F;
    head_flit_i = '0;
    for (int i = 0; i < 5; i++) gap[i] = 0;
    model_reset();
    #2;
    check_val("rst_pop",   32'(pop_req_o), 0);
    check_val("rst_busy",  32'(busy_o),    0);
    check_val("rst_valid", 32'(valid_o),   0);
    check_val("rst_sel",   32'(sel_o),     0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single-flit packet N -> E.
    push_pkt(0, MY_X + 1, MY_Y, 1);
    drive_and_check();
    check_val("a_arb_busy", 32'(busy_o[2]), 0);
    commit();
    drive_and_check();
    check_val("a_pop",   32'(pop_req_o), 32'h01);
    check_val("a_valid", 32'(valid_o[2]), 1);
    check_val("a_sel",   32'(sel_o[2]), 0);
    check_val("a_busy",  32'(busy_o[2]), 1);
    commit();
    drive_and_check();
    check_val("a_idle", 32'(busy_o[2]), 0);
    commit();

    // N and S contend for L with 3-flit packets.
    push_pkt(0, MY_X, MY_Y, 3);
    push_pkt(1, MY_X, MY_Y, 3);
    for (int c = 0; c < 9; c++) begin
      drive_and_check();
      check_val($sformatf("b_pop%0d", c), 32'(pop_req_o), 32'(b_seq[c]));
      commit();
    end
    push_pkt(0, MY_X, MY_Y, 3);
    push_pkt(1, MY_X, MY_Y, 3);
    step();
    drive_and_check();
    // Pointer for L now sits at 2, so N (0) is scanned before S (1).
    check_val("b_repeat_first", 32'(pop_req_o), 32'h01);
    commit();
    run(10);

    // Backpressure on E mid-packet.
    push_pkt(0, MY_X + 1, MY_Y, 4);
    run(3);
    ready_i[2] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_and_check();
      check_val("c_stall_pop",   32'(pop_req_o), 0);
      check_val("c_stall_valid", 32'(valid_o[2]), 0);
      check_val("c_stall_busy",  32'(busy_o[2]), 1);
      commit();
    end
    ready_i = 5'h1F;
    for (int c = 0; c < 2; c++) begin
      drive_and_check();
      check_val("c_resume_pop", 32'(pop_req_o), 32'h01);
      commit();
    end
    run(2);

    // Owner buffer empty for 3 cycles while W wants the same output.
    push_pkt(0, MY_X + 1, MY_Y, 3);
    run(2);
    gap[0] = 1;
    push_pkt(3, MY_X + 1, MY_Y, 1);
    for (int c = 0; c < 3; c++) begin
      drive_and_check();
      check_val("d_hold_pop",  32'(pop_req_o), 0);
      check_val("d_hold_busy", 32'(busy_o[2]), 1);
      commit();
    end
    gap[0] = 0;
    for (int c = 0; c < 2; c++) begin
      drive_and_check();
      check_val("d_tail_pop", 32'(pop_req_o), 32'h01);
      commit();
    end
    drive_and_check();
    check_val("d_bubble", 32'(pop_req_o), 0);
    commit();
    drive_and_check();
    check_val("d_w_pop", 32'(pop_req_o), 32'h08);
    commit();
    run(2);

    // Concurrent N -> E and W -> L.
    push_pkt(0, MY_X + 1, MY_Y, 2);
    push_pkt(3, MY_X, MY_Y, 2);
    step();
    for (int c = 0; c < 2; c++) begin
      drive_and_check();
      check_val("e_dual_pop", 32'(pop_req_o), 32'h09);
      commit();
    end
    run(2);

    // Asynchronous reset mid-packet (S -> L moves L's pointer to 2 first).
    push_pkt(1, MY_X, MY_Y, 3);
    step();
    drive_and_check();
    rst = 1'b1;
    empty_i = 5'h1F;
    #1;
    check_val("f_rst_pop",   32'(pop_req_o), 0);
    check_val("f_rst_valid", 32'(valid_o),   0);
    check_val("f_rst_busy",  32'(busy_o),    0);
    check_val("f_rst_sel",   32'(sel_o),     0);
    for (int i = 0; i < 5; i++) fifo_q[i].delete();
    model_reset();
    #1;
    rst = 1'b0;
    @(negedge clk);
    push_pkt(1, MY_X, MY_Y, 1);
    push_pkt(3, MY_X, MY_Y, 1);
    step();
    drive_and_check();
    check_val("f_ptr0_grant", 32'(pop_req_o), 32'h02);
    commit();
    run(4);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      ready_i = 5'($urandom_range(0, 31)) | 5'($urandom_range(0, 31));
      for (int i = 0; i < 5; i++) begin
        gap[i] = ($urandom_range(0, 99) < 15);
        if (fifo_q[i].size() < 4 && $urandom_range(0, 9) < 3)
          push_pkt(i, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(1, 4));
      end
      step();
    end
    ready_i = 5'h1F;
    for (int i = 0; i < 5; i++) gap[i] = 0;
    for (int c = 0; c < 400; c++) begin
      if (pending() == 0) break;
      step();
    end
    check_val("drain_done", 32'(pending()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
